// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - handshake and result bundle for the sequential multiplier
interface seq_multiplier_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N + 1);

  logic            start;
  logic            sgn;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            abort;
  logic            busy;
  logic            ready;
  logic [2*N-1:0]  product;
  logic [SW-1:0]   steps;

  modport master (
    output start, sgn, a, b, abort,
    input  busy, ready, product, steps
  );

  modport slave (
    input  start, sgn, a, b, abort,
    output busy, ready, product, steps
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add multiplier, signed/unsigned, optional early stop
module seq_multiplier #(
  parameter int N          = 8,
  parameter int EARLY_STOP = 1
) (
  input  logic              clock,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);
  localparam int KW = $clog2(N + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CYCLE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]     state;
  logic [N-1:0]   a_r, b_r;
  logic           sgn_r;
  logic [N-1:0]   m_r, q_r;
  logic [2*N-1:0] p_r;
  logic [KW-1:0]  k_r;
  logic           neg_r;
  logic           busy_r, ready_r;
  logic [2*N-1:0] product_r;
  logic [KW-1:0]  steps_r;

  // Negating -2^(N-1) wraps to 2^(N-1), which is exact when read as unsigned
  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] addend, p_final;
  logic           finish;

  assign mag_a   = (sgn_r && a_r[N-1]) ? N'(~a_r + 1'b1) : a_r;
  assign mag_b   = (sgn_r && b_r[N-1]) ? N'(~b_r + 1'b1) : b_r;
  assign addend  = q_r[0] ? ({{N{1'b0}}, m_r} << k_r) : '0;
  assign p_final = neg_r ? (~p_r + 1'b1) : p_r;
  assign finish  = (k_r == KW'(N)) || ((EARLY_STOP != 0) && (q_r == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sgn_r     <= 1'b0;
      m_r       <= '0;
      q_r       <= '0;
      p_r       <= '0;
      k_r       <= '0;
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
      product_r <= '0;
      steps_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start && !bus.abort) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            sgn_r   <= bus.sgn;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            m_r   <= mag_a;
            q_r   <= mag_b;
            p_r   <= '0;
            k_r   <= '0;
            neg_r <= sgn_r & (a_r[N-1] ^ b_r[N-1]);
            state <= CYCLE;
          end
        end
        CYCLE: begin
          // Abort outranks completion; product and steps keep their old values
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (finish) begin
            product_r <= p_final;
            steps_r   <= k_r;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            state     <= DONE;
          end else begin
            p_r <= p_r + addend;
            q_r <= q_r >> 1;
            k_r <= k_r + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.ready   = ready_r;
  assign bus.product = product_r;
  assign bus.steps   = steps_r;
endmodule
